// File: rtl/count_bcd_display.sv
// -----------------------------------------------------------------------------
// count_bcd_display
//   Samples a 7-bit count (0..127), converts it to 3-digit BCD with a serial
//   double-dabble engine (one iteration per clock, 7 iterations), and drives a
//   time-multiplexed 3-digit 7-segment display from the latched BCD result.
//
// Parameters
//   SCAN_DIV  clk cycles each digit stays enabled (>= 2)
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high reset
//   q      in   7   unsigned count from the upstream counter
//   load   in   1   sample q and start a conversion (ignored while busy)
//   busy   out  1   conversion in progress
//   valid  out  1   one-cycle pulse: bcd has just been updated
//   bcd    out  12  {hundreds,tens,units} of the last completed conversion
//   seg    out  7   segments {g,f,e,d,c,b,a}, active-high
//   an     out  3   one-hot digit enable; bit0=units, bit2=hundreds
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, a zero hundreds digit is blanked, and
//                          the tens digit is blanked when both hundreds and
//                          tens are zero. Units are always shown.
// -----------------------------------------------------------------------------
module count_bcd_display #(
    parameter int SCAN_DIV = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  q,
    input  logic        load,
    output logic        busy,
    output logic        valid,
    output logic [11:0] bcd,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int            PW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PSC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]    ITER_LAST = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    bin_q, bin_d;
    logic [11:0]   work_q, work_d;
    logic [2:0]    iter_q, iter_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [PW-1:0] psc_q, psc_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    // Double-dabble step: add 3 to every nibble >= 5, then shift the whole
    // {bcd,bin} word left by one. The adjusted word is shifted as a unit so the
    // bit leaving the top (always 0 for inputs <= 127) simply falls off.
    logic [11:0] adj;
    logic [11:0] work_shift;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (work_q[gi*4 +: 4] >= 4'd5) ?
                                    work_q[gi*4 +: 4] + 4'd3 :
                                    work_q[gi*4 +: 4];
        end
    endgenerate

    assign work_shift = (adj << 1) | {11'b0, bin_q[6]};

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Conversion FSM next-state
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        work_d  = work_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        bcd_d   = bcd_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_d   = q;
                    work_d  = 12'h000;
                    iter_d  = 3'd0;
                    busy_d  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                bin_d  = bin_q << 1;
                work_d = work_shift;
                iter_d = iter_q + 3'd1;
                if (iter_q == ITER_LAST) begin
                    bcd_d   = work_shift;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Display scan next-state. an/seg are computed from the next idx and next
    // bcd so the registered outputs always agree with the current scan slot.
    logic [3:0] nib;
    logic       blank;

    always_comb begin
        psc_d = psc_q + PW'(1);
        idx_d = idx_q;
        if (psc_q == PSC_LAST) begin
            psc_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        case (idx_d)
            2'd0:    nib = bcd_d[3:0];
            2'd1:    nib = bcd_d[7:4];
            default: nib = bcd_d[11:8];
        endcase

        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_d == 2'd2 && bcd_d[11:8] == 4'd0)
            blank = 1'b1;
        if (idx_d == 2'd1 && bcd_d[11:8] == 4'd0 && bcd_d[7:4] == 4'd0)
            blank = 1'b1;
`endif

        an_d  = 3'b001 << idx_d;
        seg_d = blank ? 7'b0000000 : seg_decode(nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bin_q   <= 7'd0;
            work_q  <= 12'h000;
            iter_q  <= 3'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bcd_q   <= 12'h000;
            psc_q   <= '0;
            idx_q   <= 2'd0;
            an_q    <= 3'b001;
            seg_q   <= 7'b0111111;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            bcd_q   <= bcd_d;
            psc_q   <= psc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign bcd   = bcd_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule
